// File: rtl/xnor_popcount_acc.sv
`default_nettype none
// ============================================================================
// Module   : xnor_popcount_acc
// Purpose  : Binary-neural-network neuron datapath. For each accepted beat,
//            counts the ones in XNOR(activation, weight) and accumulates the
//            counts over BEATS beats. It then presents the group sum together
//            with a binarised bit (sum >= threshold) until the consumer
//            accepts it.
// Ports    : CLK        - clock, rising edge
//            rst        - asynchronous active-high reset
//            clr        - synchronous soft clear (abandons current group)
//            in_valid   / in_ready  - input beat handshake
//            in_act     / in_wgt    - binary activation / weight vectors
//            threshold  - compare threshold, sampled on beat 0 of a group
//            beat_idx   - index of next beat to accept (weight-memory address)
//            out_valid  / out_ready - result handshake
//            out_sum    - accumulated XNOR popcount
//            out_bit    - 1 when out_sum >= sampled threshold
// Revision : 1.0 - initial release
// ============================================================================
module xnor_popcount_acc #(
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 8,
  parameter int ACC_WIDTH  = 9
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_act,
  input  logic [DATA_WIDTH-1:0]      in_wgt,
  input  logic [ACC_WIDTH-1:0]       threshold,
  output logic [$clog2(BEATS)-1:0]   beat_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_sum,
  output logic                       out_bit
);

  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  thr_q, thr_d;

  logic [DATA_WIDTH-1:0] xnor_vec;
  logic [ACC_WIDTH-1:0]  beat_pop;
  logic                  last_beat;

  assign xnor_vec = ~(in_act ^ in_wgt);

  // Popcount is built directly at accumulator width so the add needs no
  // further extension; ACC_WIDTH always covers DATA_WIDTH.
  always_comb begin
    beat_pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      beat_pop = beat_pop + {{(ACC_WIDTH-1){1'b0}}, xnor_vec[i]};
    end
  end

  assign last_beat = (idx_q == C_LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    thr_d   = thr_q;
    if (clr) begin
      // Clear wins over any handshake in the same cycle.
      state_d = ACCUM;
      idx_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (idx_q == '0) begin
              // First beat loads rather than adds, so no explicit
              // clear is needed between groups.
              acc_d = beat_pop;
              thr_d = threshold;
            end else begin
              acc_d = acc_q + beat_pop;
            end
            if (last_beat) begin
              idx_d   = '0;
              state_d = DONE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = ACCUM;
          end
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      acc_q   <= '0;
      thr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      thr_q   <= thr_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign beat_idx  = idx_q;
  assign out_sum   = acc_q;
  // Gated by DONE so the bit reads 0 in reset and while accumulating.
  assign out_bit   = (state_q == DONE) && (acc_q >= thr_q);

endmodule
`default_nettype wire

// File: tb/tb_xnor_popcount_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_xnor_popcount_acc
// Purpose  : Self-checking bench for xnor_popcount_acc (32-bit, 8 beats).
//            A queue-based model of accepted beats predicts outputs every
//            cycle; directed groups carry hand-computed literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xnor_popcount_acc;

  localparam int DW = 32;
  localparam int NB = 8;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] in_act = '0;
  logic [DW-1:0] in_wgt = '0;
  logic [AW-1:0] threshold = '0;
  logic          in_ready;
  logic [2:0]    beat_idx;
  logic          out_valid;
  logic [AW-1:0] out_sum;
  logic          out_bit;

  xnor_popcount_acc #(.DATA_WIDTH(DW), .BEATS(NB), .ACC_WIDTH(AW)) dut (
    .CLK(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .threshold(threshold),
    .beat_idx(beat_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_bit(out_bit)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Model: popcounts of the beats accepted in the current group.
  int q[$];
  bit mdone = 1'b0;
  int mthr  = 0;

  always @(posedge clk or posedge rst) begin
    logic [DW-1:0] x;
    if (rst || clr) begin
      q.delete();
      mdone = 1'b0;
    end else if (!mdone) begin
      if (in_valid) begin
        if (q.size() == 0) mthr = int'(threshold);
        x = ~(in_act ^ in_wgt);
        q.push_back($countones(x));
        if (q.size() == NB) mdone = 1'b1;
      end
    end else if (out_ready) begin
      q.delete();
      mdone = 1'b0;
    end
  end

  // Results seen (cycle, sum, bit) for directed literal checks.
  int vq[$];
  int sq[$];
  int bq[$];

  always @(negedge clk) begin
    int s;
    if (rst) begin
      chk("rst_beat_idx",  beat_idx,  0);
      chk("rst_out_sum",   out_sum,   0);
      chk("rst_out_bit",   out_bit,   0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready",  in_ready,  1);
    end else begin
      chk("in_ready",  in_ready,  !mdone);
      chk("out_valid", out_valid, mdone);
      chk("beat_idx",  beat_idx,  mdone ? 0 : q.size());
      if (mdone) begin
        s = q.sum();
        chk("out_sum", out_sum, s);
        chk("out_bit", out_bit, s >= mthr);
      end
      if (out_valid) begin
        vq.push_back(cyc);
        sq.push_back(int'(out_sum));
        bq.push_back(int'(out_bit));
      end
    end
  end

  task automatic clear_log();
    vq.delete(); sq.delete(); bq.delete();
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] w,
                      input logic [AW-1:0] t, output int idx);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_act    = a;
    in_wgt    = w;
    threshold = t;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("send_timeout", 1, 0);
    idx = int'(beat_idx);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_act    = $urandom;
      in_wgt    = $urandom;
      threshold = AW'($urandom);
    end
  endtask

  task automatic last_result(input string name, input int esum, input int ebit);
    if (sq.size() == 0) begin
      chk({name, "_present"}, 0, 1);
    end else begin
      chk({name, "_sum"}, sq[sq.size()-1], esum);
      chk({name, "_bit"}, bq[bq.size()-1], ebit);
    end
  endtask

  initial begin
    #50000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Identical vectors: 32 per beat, 256 total, two groups back to back.
    clear_log();
    for (int i = 0; i < 2 * NB; i++) send(32'hA5A5A5A5, 32'hA5A5A5A5, 9'd128, idx);
    idle(4);
    chk("t1_results", vq.size(), 2);
    if (vq.size() >= 2) begin
      chk("t1_sum0",   sq[0], 256);
      chk("t1_bit0",   bq[0], 1);
      chk("t1_sum1",   sq[1], 256);
      chk("t1_period", vq[1] - vq[0], 9);
    end

    // All-mismatch: sum 0; threshold 0 -> 1, threshold 1 -> 0.
    clear_log();
    for (int i = 0; i < NB; i++) send(32'hFFFFFFFF, 32'h0, 9'd0, idx);
    idle(3);
    last_result("t2a", 0, 1);
    clear_log();
    for (int i = 0; i < NB; i++) send(32'hFFFFFFFF, 32'h0, (i == 0) ? 9'd1 : 9'd0, idx);
    idle(3);
    last_result("t2b", 0, 0);

    // Popcount 16 per beat with bubbles; threshold only sampled on beat 0.
    clear_log();
    for (int i = 0; i < NB; i++) begin
      if (i % 2 == 0) send(32'hFFFF0000, 32'h0, (i == 0) ? 9'd129 : AW'($urandom), idx);
      else            send(32'h12345678, 32'h12345678 ^ 32'h0F0F0F0F, AW'($urandom), idx);
      chk("t3_beat_idx", idx, i);
      idle($urandom_range(0, 2));
    end
    idle(3);
    last_result("t3", 128, 0);

    // Backpressure: result held 5 cycles, sum == threshold boundary.
    clear_log();
    out_ready = 1'b0;
    for (int i = 0; i < NB; i++) send(32'hFFFFFFFF, 32'h000000FF, (i == 0) ? 9'd64 : 9'd0, idx);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_act = $urandom;
      in_wgt = $urandom;
      chk("t4_out_valid", out_valid, 1);
      chk("t4_in_ready",  in_ready,  0);
      chk("t4_out_sum",   out_sum,   64);
      chk("t4_out_bit",   out_bit,   1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < NB; i++) send(32'hA5A5A5A5, 32'hA5A5A5A5, 9'd300, idx);
    idle(3);
    last_result("t4", 256, 0);

    // Async reset mid-group, then clr with a beat at index 6.
    clear_log();
    for (int i = 0; i < 4; i++) send(32'h0, 32'h0, 9'd0, idx);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_async_idx", beat_idx, 0);
    chk("t5_async_sum", out_sum, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) send(32'h0, 32'h0, 9'd0, idx);
    @(negedge clk);
    chk("t5_pre_clr_idx", beat_idx, 6);
    clr = 1'b1; in_valid = 1'b1; in_act = 32'h0; in_wgt = 32'h0;
    @(posedge clk);
    #1;
    chk("t5_clr_idx",   beat_idx,  0);
    chk("t5_clr_valid", out_valid, 0);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < NB; i++) send(32'h000000FF, 32'h0, (i == 0) ? 9'd192 : AW'($urandom), idx);
    idle(3);
    last_result("t5", 192, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xnor_popcount_acc.md
XNOR_POPCOUNT_ACC -- requirements
Module: xnor_popcount_acc

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bits per input beat.
REQ-002 Parameter BEATS, default 8: beats accumulated per result; legal range 2..256.
REQ-003 Parameter ACC_WIDTH, default 9: accumulator width; SHALL be at least clog2(DATA_WIDTH*BEATS+1).
REQ-004 CLK  in  1: single clock; all state updates on its rising edge.
REQ-005 rst  in  1: reset, asynchronous and active-high.
REQ-006 clr  in  1: synchronous soft clear; abandons the current accumulation.
REQ-007 in_valid  in  1: an input beat is presented.
REQ-008 in_ready  out  1: the block accepts a beat this cycle.
REQ-009 in_act  in  DATA_WIDTH: binary activation vector.
REQ-010 in_wgt  in  DATA_WIDTH: binary weight vector.
REQ-011 threshold  in  ACC_WIDTH: comparison threshold; sampled on the first beat of each group.
REQ-012 beat_idx  out  clog2(BEATS): index of the next beat to be accepted; used as the weight-memory address.
REQ-013 out_valid  out  1: a result is held.
REQ-014 out_ready  in  1: the consumer accepts the result.
REQ-015 out_sum  out  ACC_WIDTH: accumulated XNOR popcount of the group.
REQ-016 out_bit  out  1: binarised result, 1 when out_sum >= the sampled threshold.

Function
REQ-017 The FSM SHALL have exactly two states: ACCUM and DONE.
REQ-018 in_ready SHALL be 1 in ACCUM and 0 in DONE.
REQ-019 out_valid SHALL be 1 in DONE and 0 in ACCUM.
REQ-020 Accepted beat: in_valid and in_ready both 1 at a rising edge.
REQ-021 Per accepted beat, the block SHALL add the count of ones in ~(in_act ^ in_wgt), range 0..DATA_WIDTH, to the accumulator.
REQ-022 On the beat accepted with beat_idx 0, the accumulator SHALL load that beat's popcount (not add it) and threshold SHALL be registered.
REQ-023 beat_idx SHALL increment by 1 per accepted beat and wrap from BEATS-1 to 0.
REQ-024 beat_idx SHALL hold when in_valid is 0; input bubbles SHALL NOT affect the accumulator.
REQ-025 The beat accepted at beat_idx BEATS-1 SHALL move the FSM to DONE.
REQ-026 On entering DONE, out_sum SHALL equal the full group sum; out_valid SHALL assert on the cycle after that last beat is accepted (latency 1).
REQ-027 out_bit SHALL equal (out_sum >= registered threshold), using an unsigned compare.
REQ-028 In DONE, out_sum and out_bit SHALL stay stable until out_ready is 1.
REQ-029 A rising edge in DONE with out_ready 1 SHALL return the FSM to ACCUM, with beat_idx 0.
REQ-030 Minimum period per result: BEATS+1 cycles.
REQ-031 The accumulator SHALL never overflow; its maximum is DATA_WIDTH*BEATS.
REQ-032 clr 1 at an edge SHALL force ACCUM, beat_idx 0, out_valid 0, and accumulator 0. clr has priority over any handshake in the same cycle; the beat or result present in that cycle is discarded.
REQ-033 in_act, in_wgt and threshold SHALL be ignored when no beat is accepted.

Reset
REQ-034 While rst is 1, the block SHALL be in ACCUM, with beat_idx 0, accumulator 0, out_sum 0, out_bit 0, out_valid 0 and in_ready 1.
REQ-035 Reset asserted mid-group or in DONE SHALL discard all partial state immediately, without waiting for a CLK edge.
REQ-036 After rst deasserts, the first accepted beat SHALL be treated as beat 0.

Verification (DATA_WIDTH=32, BEATS=8)
REQ-037 Stimulus: 8 beats, in_act=in_wgt=0xA5A5A5A5, threshold 128, out_ready 1. Required response: out_sum 256, out_bit 1, out_valid exactly 1 cycle, 9 cycles per result.
REQ-038 Stimulus: 8 beats, in_act=0xFFFFFFFF, in_wgt=0, threshold 0. Required response: out_sum 0 and out_bit 1; repeating with threshold 1 gives out_bit 0.
REQ-039 Stimulus: mixed beats, each with popcount 16, threshold 129, in_valid toggled randomly. Required response: out_sum 128, out_bit 0; beat_idx sequence 0..7 unaffected by bubbles.
REQ-040 Stimulus: out_ready held 0 for 5 cycles after the result. Required response: out_valid and out_sum stable and in_ready 0 throughout; the next group starts only after the out_ready handshake.
REQ-041 Stimulus: rst pulsed after 4 beats, then clr asserted together with a valid beat at beat_idx 6. Required response: both abort; the next full group sums from zero, and the discarded beat is not counted.
